intr_arbiter: RTL
=================

Name: intr_arbiter

Overview:
- Shares the MCU's single interrupt input among N_SRC requesters, such as the button interrupt FSM, timers and I/O peripherals.
- Captures request rising edges as pending bits and applies a mask register.
- Grants one source at a time, holds the interrupt until the MCU acknowledges it or a timeout expires, then enforces a cooldown gap.
- Sits between peripheral request lines and the MCU INTR pin; src_id is readable through an MCU IN port.

Parameters:
- N_SRC, 4, number of requesters (2..8).
- HOLD_MAX, 16, maximum cycles intr stays high without ack (>=1).
- GAP_CYCLES, 4, minimum cooldown cycles after a grant ends (>=1).
- MASK_RST, all ones, reset value of mask.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_SRC  request lines; level, rising edge significant.
- mask_wr  in  1  write strobe for the mask register.
- mask_data  in  N_SRC  new mask value; bit=1 enables the source.
- int_ack  in  1  MCU acknowledge (ISR entry).
- intr  out  1  interrupt to MCU.
- src_valid  out  1  high while a grant is active.
- src_id  out  $clog2(N_SRC)  index of the granted or last granted source.
- pending  out  N_SRC  pending request bits.
- mask  out  N_SRC  current mask.
- state_dbg  out  3  one-hot state, for PMOD debug.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pending=0, req_d=0, mask=MASK_RST, src_id=0, counter=0.
  - intr=0, src_valid=0, state_dbg=3'b001.
- Edge capture:
  - A rising edge is req[i]=1 at a clock edge while req_d[i]=0.
  - Each captured edge sets pending[i] at that edge.
  - A held level sets pending only once.
- Mask:
  - mask_wr=1 loads mask_data at the clock edge.
  - A masked pending bit is retained but is not eligible.
  - eligible = pending & mask, combinational from registers.
- State IDLE (state_dbg=001):
  - If eligible is nonzero, go to GRANT at the next edge and latch src_id = picked index.
  - Fixed priority: lowest index wins.
- State GRANT (state_dbg=010):
  - intr=1 and src_valid=1, Moore-decoded from the state register.
  - The counter increments each cycle.
  - int_ack=1: clear pending[src_id], go to COOLDOWN, counter cleared.
  - No ack with counter==HOLD_MAX-1: go to COOLDOWN with pending kept (retry later).
  - intr is therefore high for at most HOLD_MAX cycles.
  - Mask changes during GRANT do not revoke the active grant.
- State COOLDOWN (state_dbg=100):
  - intr=0 and src_valid=0; the counter increments.
  - Go to IDLE when counter>=GAP_CYCLES-1 AND int_ack=0.
  - A stuck ack therefore extends COOLDOWN.
- Latency:
  - req edge captured at edge k, so pending is set after k.
  - intr=1 after edge k+1 if the arbiter was IDLE.
- Simultaneous events:
  - A new edge on req[src_id] in the same cycle as ack: the set wins, so the bit stays pending.
  - Multiple edges in one cycle all set their pending bits.
- int_ack outside GRANT is ignored, except that a high ack holds COOLDOWN.
- Illegal state encoding recovers to IDLE on the next edge (default branch); outputs in the default branch are intr=0, state_dbg=000.
- Reset mid-GRANT drops intr immediately and clears all pending bits.
- Counter width is $clog2(max(HOLD_MAX,GAP_CYCLES)+1).
- src_id holds its last value outside GRANT.

Optional Feature:
- Macro: INTR_ARB_ROUND_ROBIN_EN.
- Defined: rotating priority.
  - A last-grant pointer (reset 0) updates on every GRANT entry.
  - The search starts at (last+1) mod N_SRC.
- Undefined: fixed lowest-index priority and no pointer register.

Decomposition:
- Package intr_arb_pkg:
  - state enum IDLE/GRANT/COOLDOWN.
  - Constants STATE_DBG_IDLE=3'b001, STATE_DBG_GRANT=3'b010, STATE_DBG_COOLDOWN=3'b100.
- Sub-module intr_prio_pick: a combinational picker.
  - Inputs: eligible vector and a start index (tied 0 when fixed).
  - Outputs: any and index.

Test Plan (N_SRC=4, HOLD_MAX=16, GAP_CYCLES=4):
- Reset: rst_n=0 for 2 cycles, then release -> intr=0, pending=4'b0000, mask=4'b1111, state_dbg=001, src_id=0.
- req[2] rises at edge k, ack pulse at edge k+3:
  - pending=4'b0100 after k.
  - intr=1, src_id=2, state_dbg=010 after k+1.
  - After k+3: pending=0 and state_dbg=100.
  - state_dbg=001 exactly 4 cycles later (ack low).
- req[1] and req[3] rise in the same cycle -> grant src_id=1 first; after ack and cooldown, grant src_id=3.
  - ROUND_ROBIN_EN: prior grant 1, then 1 and 3 pending -> grant 3 first.
- No ack -> intr high exactly 16 cycles, pending[2] stays 1, 4 cycles COOLDOWN, then intr re-asserts with src_id=2.
- Mask gating:
  - mask write 4'b1011, then req[2] rises -> pending=4'b0100 and intr stays 0 for 50 cycles.
  - Write 4'b1111 at edge m -> intr=1 after m+1.
- Edge and reset corners:
  - req[0] held high 100 cycles, ack once -> pending[0]=0 afterwards and no regrant.
  - rst_n asserted mid-GRANT -> intr=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/intr_arb_pkg.sv
// Shared types and debug encodings for the interrupt arbiter.
package intr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GRANT    = 2'b01,
    COOLDOWN = 2'b10
  } state_e;

  localparam logic [2:0] STATE_DBG_IDLE     = 3'b001;
  localparam logic [2:0] STATE_DBG_GRANT    = 3'b010;
  localparam logic [2:0] STATE_DBG_COOLDOWN = 3'b100;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/intr_prio_pick.sv
// Combinational priority picker: first eligible bit found scanning upward
// from start, wrapping around modulo N_SRC.
module intr_prio_pick #(
  parameter int N_SRC = 4,
  parameter int IW    = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] eligible,
  input  logic [IW-1:0]    start,
  output logic             any,
  output logic [IW-1:0]    index
);

  logic [IW-1:0] pos;

  always_comb begin
    any   = 1'b0;
    index = '0;
    pos   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      pos = IW'((int'(start) + i) % N_SRC);
      if (!any && eligible[pos]) begin
        any   = 1'b1;
        index = pos;
      end
    end
  end

endmodule

// File: rtl/intr_arbiter.sv
// Shares one MCU interrupt line among N_SRC edge-triggered requesters.
// Define INTR_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed lowest-index.
module intr_arbiter
  import intr_arb_pkg::*;
#(
  parameter int               N_SRC      = 4,
  parameter int               HOLD_MAX   = 16,
  parameter int               GAP_CYCLES = 4,
  parameter logic [N_SRC-1:0] MASK_RST   = '1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC-1:0]         req,
  input  logic                     mask_wr,
  input  logic [N_SRC-1:0]         mask_data,
  input  logic                     int_ack,
  output logic                     intr,
  output logic                     src_valid,
  output logic [$clog2(N_SRC)-1:0] src_id,
  output logic [N_SRC-1:0]         pending,
  output logic [N_SRC-1:0]         mask,
  output logic [2:0]               state_dbg
);

  localparam int IW = $clog2(N_SRC);
  localparam int CW = $clog2(max_int(HOLD_MAX, GAP_CYCLES) + 1);

  state_e           state, state_nxt;
  logic [N_SRC-1:0] req_d, pend, mask_r, edges, eligible, clr;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [IW-1:0]    id_r, id_nxt, start, pick_idx;
  logic             pick_any;

  assign edges     = req & ~req_d;
  assign eligible  = pend & mask_r;
  assign pending   = pend;
  assign mask      = mask_r;
  assign src_id    = id_r;

`ifdef INTR_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] last;
  assign start = (last == IW'(N_SRC - 1)) ? '0 : last + 1'b1;
`else
  assign start = '0;
`endif

  intr_prio_pick #(.N_SRC(N_SRC), .IW(IW)) u_pick (
    .eligible (eligible),
    .start    (start),
    .any      (pick_any),
    .index    (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    id_nxt    = id_r;
    clr       = '0;
    intr      = 1'b0;
    src_valid = 1'b0;
    state_dbg = 3'b000;
    case (state)
      IDLE: begin
        state_dbg = STATE_DBG_IDLE;
        cnt_nxt   = '0;
        if (pick_any) begin
          state_nxt = GRANT;
          id_nxt    = pick_idx;
        end
      end
      GRANT: begin
        state_dbg = STATE_DBG_GRANT;
        intr      = 1'b1;
        src_valid = 1'b1;
        if (int_ack) begin
          clr[id_r] = 1'b1;
          state_nxt = COOLDOWN;
          cnt_nxt   = '0;
        end else if (cnt == CW'(HOLD_MAX - 1)) begin
          // Timed out: leave pending set so the source is retried.
          state_nxt = COOLDOWN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      COOLDOWN: begin
        state_dbg = STATE_DBG_COOLDOWN;
        // Counter saturates so a stuck ack can hold this state indefinitely.
        if (cnt >= CW'(GAP_CYCLES - 1)) begin
          if (!int_ack) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      id_r   <= '0;
      req_d  <= '0;
      pend   <= '0;
      mask_r <= MASK_RST;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      id_r   <= id_nxt;
      req_d  <= req;
      // A fresh edge wins over the acknowledge clear.
      pend   <= (pend & ~clr) | edges;
      if (mask_wr) mask_r <= mask_data;
    end
  end

`ifdef INTR_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last <= '0;
    else if (state == IDLE && pick_any) last <= pick_idx;
  end
`endif

endmodule
